// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: fetch FSM encoding, datapath width, NOP word.
package instr_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Turn a 30-bit word index back into a word-aligned byte address.
  function automatic logic [XLEN-1:0] word_to_byte(input logic [XLEN-3:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register. Stored as a word index so the two low byte-address
// bits are zero by construction. Load has priority over increment; otherwise hold.
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [29:0] load_word,
  output logic [29:0] pc_word
);

  logic [29:0] pc_word_reg;

  // PC update: reset vector, redirect, sequential advance, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_word_reg <= RESET_VALUE[31:2];
    end else if (load) begin
      pc_word_reg <= load_word;
    end else if (inc) begin
      pc_word_reg <= pc_word_reg + 30'd1;
    end
  end

  assign pc_word = pc_word_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the BOOT/RUN/HALT sequencer and the IF/ID
// pipeline register. Instruction memory lives outside and is read
// combinationally through imem_addr/imem_data.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ROM_SIZE     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_fault
);

  localparam logic [29:0] ROM_LIMIT = 30'(ROM_SIZE);

  fetch_state_t state_reg;
  logic [31:0]  if_pc_reg;
  logic [31:0]  if_pc4_reg;
  logic [31:0]  if_instr_reg;
  logic         if_valid_reg;
  logic         if_fault_reg;

  logic [29:0]  pc_word;
  logic [31:0]  pc_byte;
  logic         out_of_range;
  logic         pc_load;
  logic         pc_inc;

  assign pc_byte      = word_to_byte(pc_word);
  assign imem_addr    = {2'b00, pc_word};
  assign out_of_range = (pc_word >= ROM_LIMIT);

  // A redirect is always honoured in RUN, even toward an out-of-range target;
  // the range check then fires on the following cycle. Flush overrides stall
  // so the squashed slot still advances the PC.
  assign pc_load = (state_reg == RUN) && branch_taken;
  assign pc_inc  = (state_reg == RUN) && !branch_taken && !out_of_range &&
                   (flush || !stall);

  instr_fetch_pc_reg #(
    .RESET_VALUE (RESET_VECTOR)
  ) pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_word (branch_target[31:2]),
    .pc_word   (pc_word)
  );

  // Fetch sequencer and IF/ID register; priority branch > range fault > flush > stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= BOOT;
      if_pc_reg    <= 32'd0;
      if_pc4_reg   <= 32'd4;
      if_instr_reg <= NOP_WORD;
      if_valid_reg <= 1'b0;
      if_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            if_valid_reg <= 1'b0;
          end else if (out_of_range) begin
            state_reg    <= HALT;
            if_fault_reg <= 1'b1;
            if_valid_reg <= 1'b0;
          end else if (flush) begin
            if_valid_reg <= 1'b0;
          end else if (!stall) begin
            if_pc_reg    <= pc_byte;
            if_pc4_reg   <= pc_byte + 32'd4;
            if_instr_reg <= imem_data;
            if_valid_reg <= 1'b1;
          end
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

  assign if_pc    = if_pc_reg;
  assign if_pc4   = if_pc4_reg;
  assign if_instr = if_instr_reg;
  assign if_valid = if_valid_reg;
  assign if_fault = if_fault_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the pipeline-control
// cases plus hand sequences for the range fault, HALT and async reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_fault;

  int checks;
  int failures;

  logic [31:0] rom [64];

  typedef struct {
    logic        s;
    logic        f;
    logic        b;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [19];

  instr_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .ROM_SIZE     (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_instr      (if_instr),
    .if_valid      (if_valid),
    .if_fault      (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory model
  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'd64) imem_data = rom[imem_addr[5:0]];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " if_pc"},     if_pc,     32'h0);
    check({tag, " if_pc4"},    if_pc4,    32'h4);
    check({tag, " if_instr"},  if_instr,  32'h0);
    check({tag, " if_valid"},  {31'd0, if_valid}, 32'h0);
    check({tag, " if_fault"},  {31'd0, if_fault}, 32'h0);
    check({tag, " imem_addr"}, imem_addr, 32'h0);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_pc;
    bit          halted;

    checks = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h11 * (i + 1);

    //         s  f  b  tgt         v  pc          instr        addr
    vecs[0]  = '{0, 0, 0, 32'h0,  0, 32'h00, 32'h00, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,  1, 32'h00, 32'h11, 32'h1};
    vecs[2]  = '{0, 0, 0, 32'h0,  1, 32'h04, 32'h22, 32'h2};
    vecs[3]  = '{0, 0, 0, 32'h0,  1, 32'h08, 32'h33, 32'h3};
    vecs[4]  = '{1, 0, 0, 32'h0,  1, 32'h08, 32'h33, 32'h3};
    vecs[5]  = '{1, 0, 0, 32'h0,  1, 32'h08, 32'h33, 32'h3};
    vecs[6]  = '{1, 0, 0, 32'h0,  1, 32'h08, 32'h33, 32'h3};
    vecs[7]  = '{0, 0, 0, 32'h0,  1, 32'h0C, 32'h44, 32'h4};
    vecs[8]  = '{0, 0, 1, 32'h23, 0, 32'h0C, 32'h44, 32'h8};
    vecs[9]  = '{0, 0, 0, 32'h0,  1, 32'h20, 32'h99, 32'h9};
    vecs[10] = '{0, 0, 0, 32'h0,  1, 32'h24, 32'hAA, 32'hA};
    vecs[11] = '{0, 0, 1, 32'h0,  0, 32'h24, 32'hAA, 32'h0};
    vecs[12] = '{0, 0, 0, 32'h0,  1, 32'h00, 32'h11, 32'h1};
    vecs[13] = '{0, 0, 0, 32'h0,  1, 32'h04, 32'h22, 32'h2};
    vecs[14] = '{1, 1, 0, 32'h0,  0, 32'h04, 32'h22, 32'h3};
    vecs[15] = '{0, 0, 0, 32'h0,  1, 32'h0C, 32'h44, 32'h4};
    vecs[16] = '{1, 1, 1, 32'h8,  0, 32'h0C, 32'h44, 32'h2};
    vecs[17] = '{0, 1, 0, 32'h0,  0, 32'h0C, 32'h44, 32'h3};
    vecs[18] = '{0, 0, 0, 32'h0,  1, 32'h0C, 32'h44, 32'h4};

    clear_inputs();
    rst = 1'b1;
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven pipeline control
    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].s;
      flush = vecs[i].f;
      branch_taken = vecs[i].b;
      branch_target = vecs[i].tgt;
      tick();
      $display("vec %0d s=%0d f=%0d b=%0d -> valid=%0d if_pc=%h instr=%h addr=%h",
               i, vecs[i].s, vecs[i].f, vecs[i].b, if_valid, if_pc, if_instr, imem_addr);
      check($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d if_pc4", i), if_pc4, vecs[i].exp_pc + 32'd4);
      check($sformatf("vec%0d if_instr", i), if_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d if_fault", i), {31'd0, if_fault}, 32'h0);
    end
    clear_inputs();

    // Async reset mid-run, then straight-line run off the end of the ROM
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrun_reset");
    rst = 1'b0;
    last_pc = 32'hFFFF_FFFF;
    halted = 1'b0;
    for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
      tick();
      if (if_valid) last_pc = if_pc;
      if (if_fault) halted = 1'b1;
    end
    $display("rom run: halted=%0d last_pc=%h valid=%0d addr=%h", halted, last_pc, if_valid, imem_addr);
    check("rom_run halted", {31'd0, halted}, 32'h1);
    check("rom_run last_pc", last_pc, 32'hFC);
    check("rom_run if_valid", {31'd0, if_valid}, 32'h0);
    check("rom_run imem_addr", imem_addr, 32'h40);

    // HALT ignores branch, flush and stall
    branch_taken = 1'b1; branch_target = 32'h0; flush = 1'b1; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("halt hold %0d: fault=%0d valid=%0d addr=%h", k, if_fault, if_valid, imem_addr);
      check($sformatf("halt%0d imem_addr", k), imem_addr, 32'h40);
      check($sformatf("halt%0d if_fault", k), {31'd0, if_fault}, 32'h1);
      check($sformatf("halt%0d if_valid", k), {31'd0, if_valid}, 32'h0);
      check($sformatf("halt%0d if_pc", k), if_pc, 32'hFC);
    end

    // Async reset between edges while halted
    #2;
    rst = 1'b1;
    clear_inputs();
    #1;
    $display("halt reset: fault=%0d valid=%0d addr=%h", if_fault, if_valid, imem_addr);
    check_reset_values("halt_reset");
    rst = 1'b0;
    tick();
    check("restart boot if_valid", {31'd0, if_valid}, 32'h0);
    tick();
    $display("restart: valid=%0d if_pc=%h instr=%h", if_valid, if_pc, if_instr);
    check("restart if_valid", {31'd0, if_valid}, 32'h1);
    check("restart if_pc", if_pc, 32'h0);
    check("restart if_instr", if_instr, 32'h11);

    // Branch to an out-of-range target is accepted, then faults
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    clear_inputs();
    $display("oor branch: valid=%0d fault=%0d addr=%h", if_valid, if_fault, imem_addr);
    check("oor_br imem_addr", imem_addr, 32'h80);
    check("oor_br if_valid", {31'd0, if_valid}, 32'h0);
    check("oor_br if_fault", {31'd0, if_fault}, 32'h0);
    tick();
    $display("oor halt: valid=%0d fault=%0d addr=%h", if_valid, if_fault, imem_addr);
    check("oor_halt if_fault", {31'd0, if_fault}, 32'h1);
    check("oor_halt if_valid", {31'd0, if_valid}, 32'h0);
    tick();
    check("oor_hold imem_addr", imem_addr, 32'h80);
    check("oor_hold if_fault", {31'd0, if_fault}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
